// File: rtl/seq_detect_moore_nol.sv
// Moore serial pattern detector, non-overlapping: y is high for one cycle after
// each complete PATTERN (MSB received first); matching restarts after a detection.
module seq_detect_moore_nol #(
  parameter int unsigned     LEN     = 4,
  parameter logic [LEN-1:0]  PATTERN = 4'b1001
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  output logic y
);

  localparam int unsigned CW   = $clog2(LEN + 1);
  localparam int unsigned ROWS = 2 ** CW;

  typedef enum logic {ST_MATCH, ST_DETECT} phase_t;

  phase_t          phase, phase_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CW-1:0]   idx, nk;
  logic [CW-1:0]   nxt_tbl [ROWS][2];

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic int unsigned next_match(input int unsigned k, input logic b);
    logic [16:0] s;
    logic        ok;
    int unsigned n;
    int unsigned best;
    s    = '0;
    best = 0;
    if (k < LEN) begin
      for (int unsigned i = 0; i < k; i++) s[i] = PATTERN[LEN-1-i];
      s[k] = b;
      n    = k + 1;
      for (int unsigned j = 1; j <= n; j++) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < j; i++)
          if (PATTERN[LEN-1-i] != s[n-j+i]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Rows at or beyond LEN are unreachable match counts; they all map to S0.
  for (genvar k = 0; k < ROWS; k++) begin : g_row
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int unsigned NX = next_match(k, b == 1);
      assign nxt_tbl[k][b] = CW'(NX);
    end
  end

  // DETECT behaves exactly like S0, so bits of a detected pattern are never reused.
  always_comb begin
    phase_n = ST_MATCH;
    cnt_n   = '0;
    idx     = (phase == ST_DETECT) ? '0 : cnt;
    nk      = nxt_tbl[idx][x];
    if (nk == CW'(LEN)) phase_n = ST_DETECT;
    else                cnt_n   = nk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= ST_MATCH;
      cnt   <= '0;
    end else begin
      phase <= phase_n;
      cnt   <= cnt_n;
    end
  end

  assign y = (phase == ST_DETECT);

endmodule

// File: tb/tb_seq_detect_moore_nol.sv
// Directed bench for seq_detect_moore_nol: default "1001" instance and a
// LEN=3 "101" instance, with hand-computed per-cycle expected y.
module tb_seq_detect_moore_nol;

  logic clk = 1'b0;
  logic rst_a, rst_b, x;
  logic y_a, y_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_detect_moore_nol dut_a (
    .clk (clk),
    .rst (rst_a),
    .x   (x),
    .y   (y_a)
  );

  seq_detect_moore_nol #(
    .LEN     (3),
    .PATTERN (3'b101)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .x   (x),
    .y   (y_b)
  );

  task automatic check(input string tag, input bit sel, input logic exp);
    logic obs;
    obs = sel ? y_b : y_a;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: y observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reset edge on the selected instance with a random x; y must be 0 afterwards.
  task automatic reset_edge(input string tag, input bit sel);
    @(negedge clk);
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    x = 1'($urandom);
    @(posedge clk);
    #1 check(tag, sel, 1'b0);
    @(negedge clk);
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
  endtask

  // Feed n bits (bits[n-1] first) and check y after each sampling edge.
  task automatic run(input string tag, input bit sel, input logic [31:0] bits,
                     input logic [31:0] ey, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      x = bits[i];
      @(posedge clk);
      #1 check($sformatf("%s[bit%0d]", tag, n - i), sel, ey[i]);
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    x     = 1'b0;

    // Reset held for two edges with x toggling.
    @(negedge clk); x = 1'b1;
    @(posedge clk); #1 check("rst_hold0", 1'b0, 1'b0);
    @(negedge clk); x = 1'b0;
    @(posedge clk); #1 check("rst_hold1", 1'b0, 1'b0);
    @(negedge clk); rst_a = 1'b0;

    run("basic", 1'b0, 32'b1001, 32'b0001, 4);
    reset_edge("rst_in_detect", 1'b0);

    run("nonovl", 1'b0, 32'b1001001, 32'b0001000, 7);
    reset_edge("rst_a1", 1'b0);
    run("fb_11001", 1'b0, 32'b11001, 32'b00001, 5);
    reset_edge("rst_a2", 1'b0);
    run("fb_101001", 1'b0, 32'b101001, 32'b000001, 6);
    reset_edge("rst_a3", 1'b0);
    run("fb_10001001", 1'b0, 32'b10001001, 32'b00000001, 8);
    reset_edge("rst_a4", 1'b0);
    run("long", 1'b0, 32'b100101100100101001, 32'b000100000100000001, 18);

    // Mid-match reset: partial 100 is discarded.
    reset_edge("rst_a5", 1'b0);
    run("mid_pre", 1'b0, 32'b100, 32'b000, 3);
    @(negedge clk); rst_a = 1'b1; x = 1'b1;
    @(posedge clk); #1 check("mid_rst", 1'b0, 1'b0);
    @(negedge clk); rst_a = 1'b0;
    run("mid_post", 1'b0, 32'b10010, 32'b00010, 5);

    // LEN=3, PATTERN=101 instance.
    rst_a = 1'b1;
    reset_edge("rst_b0", 1'b1);
    run("p101_a", 1'b1, 32'b10101, 32'b00100, 5);
    reset_edge("rst_b1", 1'b1);
    run("p101_b", 1'b1, 32'b101101, 32'b001001, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detect_moore_nol.md
Name: seq_detect_moore_nol

Overview:
- Moore-type serial pattern detector, non-overlapping.
- Samples one input bit `x` per rising clock edge and raises `y` for exactly one cycle after a complete occurrence of the programmed bit pattern.
- After a detection, matching restarts from scratch, so no bits of a detected pattern are reused.
- Used as a small control-path monitor on a serial bit stream.

Parameters:
- LEN, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1001, the target sequence, LEN bits wide. The MSB is the first bit received. Default detects "1001".

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- x    input  1  serial data bit, sampled on each rising edge of clk.
- y    output 1  detect flag; high for one cycle per detected pattern.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - rst=1 at a rising edge: state <= S0 (IDLE, zero bits matched) and y=0 from that edge. x is ignored that cycle.
  - Reset has priority over everything else, including mid-match and while in DETECT.
- States: S0..S(LEN-1), where Sk means the first k pattern bits are matched, plus DETECT (= S_LEN). Encoding is free (binary or one-hot).
- Moore output: y = (state == DETECT), decoded only from the state register. There is no combinational path from x to y.
  - Latency: the edge that samples the last pattern bit moves the FSM into DETECT; y is high for the following clock period.
- Transition from Sk, k < LEN, with sampled bit b:
  - If b == PATTERN[LEN-1-k], go to S(k+1).
  - Otherwise go to Sj, where j is the longest prefix of PATTERN (j ≤ k) that equals a suffix of (the first k pattern bits followed by b).
  - This is the KMP failure fallback. It must be resolved at elaboration (function/generate); runtime searching is not allowed.
- Transition from DETECT with sampled bit b (non-overlap rule): behave exactly as S0.
  - b == PATTERN[LEN-1] → S1; else → S0.
  - Bits of the just-detected pattern are never reused.
- Back-to-back patterns: y is high on non-adjacent cycles only. The minimum spacing between y pulses is LEN cycles.
- Default pattern 1001 fallbacks:
  - S0: 0→S0.
  - S1: 1→S1.
  - S2: 1→S1.
  - S3: 0→S0.
- Unreachable state encodings, if any, recover to S0 on the next edge.
- No X-propagation onto y after the first reset.

Test Plan:
- Reset: hold rst=1 for 2 edges with x toggling → y=0 throughout; after release, the stream 1,0,0,1 gives y=1 for exactly one cycle, starting on the edge that samples the final 1.
- Non-overlap: stream 1,0,0,1,0,0,1 → exactly one y pulse, after the 4th bit; the trailing "001" does not fire. An overlapping implementation would fire twice and must fail.
- Fallbacks: stream 1,1,0,0,1 → one pulse after the 5th bit; stream 1,0,1,0,0,1 → one pulse after the 6th bit; stream 1,0,0,0,1,0,0,1 → one pulse, after the 8th bit only.
- Long stream, one bit per cycle: 1,0,0,1,0,1,1,0,0,1,0,0,1,0,1,0,0,1 → y pulses after bits 4, 10 and 18 only. Check against a non-overlapping golden model.
- Mid-match reset: 1,0,0 then rst=1 for one edge, then 1 → no pulse; a full 1,0,0,1 must follow before y=1.
- Parameter variant: LEN=3, PATTERN=3'b101; stream 1,0,1,0,1 → one pulse after bit 3 only, since non-overlap suppresses bit 5. Stream 1,0,1,1,0,1 → pulses after bits 3 and 6.
